serial_tx_arbiter: RTL and testbench
====================================

Name: serial_tx_arbiter

Overview:
- Shares the single UART transmitter (txStart/txData/txBusy) among NREQ requesters. Example requesters: the command-response writer, a periodic histogram streamer and a trigger-event reporter.
- Grants are packet-atomic: once a requester is granted, its whole packet of req_len bytes is sent before any other requester is served.
- Requester selection is round-robin.
- Sits between the requester blocks and the UART TX core on the board clock.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LENW, 6, width of each packet-length field; max packet = 2^LENW-1 bytes.

Ports:
- clk  in  1  board clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester packet request; level, held until done.
- req_len  in  NREQ*LENW  packet length in bytes; requester i uses bits [i*LENW +: LENW]; stable while req[i] is high.
- req_data  in  NREQ*8  current byte; requester i uses bits [i*8 +: 8].
- grant  out  NREQ  one-hot; marks the requester currently owning the transmitter.
- byte_ack  out  NREQ  1-cycle pulse: the current byte of requester i was captured; the requester presents the next byte by the following clock edge.
- done  out  NREQ  1-cycle pulse when requester i's packet is finished.
- txBusy  in  1  UART transmitter busy.
- txStart  out  1  1-cycle start pulse to the UART.
- txData  out  8  byte to transmit; valid while txStart is high and held until the next load.

Behaviour:
- Reset values, asynchronous: grant=0, byte_ack=0, done=0, txStart=0, txData=0, rr_ptr=NREQ-1, byte count=0, state=IDLE.
- Reset mid-packet aborts the packet immediately. No done pulse is issued for it.
- States: IDLE, LOAD, GAP, FINISH.
- IDLE:
  - If req is nonzero, pick the first index with req set, searching cyclically from rr_ptr+1 (rr_ptr+1 first, then wrapping).
  - Next cycle: grant becomes one-hot for that index, rr_ptr takes that index, and the byte count loads req_len.
  - Go to FINISH if len==0, else LOAD.
  - If req is zero, stay in IDLE.
- LOAD:
  - Wait while txBusy=1.
  - When txBusy=0: txData<=req_data of the granted requester, txStart<=1, byte_ack[g]<=1, byte count decrements. Go to GAP.
- GAP (exactly 1 cycle):
  - txStart, byte_ack deassert.
  - txBusy is ignored in this cycle, covering the UART's one-cycle busy latency.
  - If the byte count is 0, go to FINISH, else LOAD.
- FINISH:
  - done[g]<=1 for one cycle, grant<=0. Return to IDLE.
  - The next arbitration happens in the IDLE cycle after that, so the minimum gap between packets is 2 cycles after done.
- Latency: req high while idle gives grant after 1 cycle. The first txStart follows 1 cycle later if txBusy=0.
- Per-byte throughput: at most one byte per 2 cycles, plus UART busy time.
- Packets are atomic:
  - Requests arriving mid-packet wait.
  - Dropping req[g] mid-packet is ignored; the remaining bytes are still sent from req_data.
  - Requester obligation: keep req high until done.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NREQ-1,0. No requester waits more than NREQ-1 packets.
- Simultaneous done[i] and a new req[i] rising in the same cycle: the new request is arbitered normally in the following IDLE cycle; the pointer makes i lowest priority.
- Only one bit of grant, byte_ack and done is ever high at a time. txStart is never high on two consecutive cycles.

Test Plan:
- Single packet: req[0]=1, len=3, bytes 0xA1,0xA2,0xA3, UART busy 10 cycles per byte → three txStart pulses carrying A1,A2,A3, each ≥11 cycles apart; done[0] once; byte_ack[0] ×3.
- Round-robin: req=4'b1111, all len=1, hold each req until its done → grant order 0,1,2,3,0; no index granted twice before all others are served.
- Atomicity: requester 2 sending len=5 while req[1] rises after byte 2 → all 5 bytes of requester 2 are sent, then requester 1 is granted; no interleaved bytes.
- Zero length: req[3]=1, len=0 → grant[3] for 1 cycle, done[3] pulse, no txStart.
- Busy hold-off: txBusy held high for 50 cycles at packet start → no txStart and no byte_ack during that time; the first txStart comes 1 cycle after txBusy falls.
- Reset mid-packet: assert reset after byte 2 of 4 → all outputs go to 0 immediately; after release with req still high, requester 0 is granted first (rr_ptr=NREQ-1) and the packet is resent in full.

Source files
------------

// File: rtl/serial_tx_arbiter.sv
// rtl/serial_tx_arbiter.sv - packet-atomic round-robin arbiter sharing one UART transmitter
module serial_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int LENW = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] req_len,
  input  logic [NREQ*8-1:0]    req_data,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      byte_ack,
  output logic [NREQ-1:0]      done,
  input  logic                 txBusy,
  output logic                 txStart,
  output logic [7:0]           txData
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GAP, S_FINISH} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_gidx;
  logic [LENW-1:0]   r_cnt;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_ack;
  logic [NREQ-1:0]   r_done;
  logic              r_start;
  logic [7:0]        r_data;
  logic [IW-1:0]     w_pick;
  logic              w_found;
  logic [LENW-1:0]   w_pick_len;
  logic              w_arb;

  // Scan offsets from NREQ down to 1 so the smallest offset after r_ptr wins.
  always_comb begin : pick
    int idx;
    w_pick  = '0;
    w_found = 1'b0;
    idx     = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(r_ptr) + k) % NREQ;
      if (req[idx]) begin
        w_pick  = IW'(idx);
        w_found = 1'b1;
      end
    end
  end

  assign w_pick_len = req_len[int'(w_pick)*LENW +: LENW];

  // The done cycle is skipped so a requester still holding req is not re-served.
  assign w_arb = (r_state == S_IDLE) && w_found && (r_done == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_arb) w_next = (w_pick_len == '0) ? S_FINISH : S_LOAD;
      S_LOAD:   if (!txBusy) w_next = S_GAP;
      S_GAP:    w_next = (r_cnt == '0) ? S_FINISH : S_LOAD;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= IW'(NREQ-1);
      r_gidx  <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_start <= 1'b0;
      r_data  <= '0;
    end else begin
      r_start <= 1'b0;
      r_ack   <= '0;
      r_done  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_arb) begin
            r_grant <= ONE << w_pick;
            r_ptr   <= w_pick;
            r_gidx  <= w_pick;
            r_cnt   <= w_pick_len;
          end
        end
        S_LOAD: begin
          if (!txBusy) begin
            r_data  <= req_data[int'(r_gidx)*8 +: 8];
            r_start <= 1'b1;
            r_ack   <= ONE << r_gidx;
            r_cnt   <= r_cnt - LENW'(1);
          end
        end
        S_FINISH: begin
          r_done  <= ONE << r_gidx;
          r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

  assign grant    = r_grant;
  assign byte_ack = r_ack;
  assign done     = r_done;
  assign txStart  = r_start;
  assign txData   = r_data;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb/tb_serial_tx_arbiter.sv - directed self-checking bench for serial_tx_arbiter
module tb_serial_tx_arbiter;

  localparam int NREQ = 4;
  localparam int LENW = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ*8-1:0]    req_data;
  logic [NREQ-1:0]      grant;
  logic [NREQ-1:0]      byte_ack;
  logic [NREQ-1:0]      done;
  logic                 txBusy;
  logic                 txStart;
  logic [7:0]           txData;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_start = 0;
  int n_ack = 0;
  int n_done = 0;
  int viol = 0;
  logic prev_start = 1'b0;

  serial_tx_arbiter #(.NREQ(NREQ), .LENW(LENW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_data(req_data),
    .grant(grant), .byte_ack(byte_ack), .done(done),
    .txBusy(txBusy), .txStart(txStart), .txData(txData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (txStart) n_start++;
    if (byte_ack != '0) n_ack++;
    if (done != '0) n_done++;
    if (txStart && prev_start) viol++;
    if (!$onehot0(grant) || !$onehot0(byte_ack) || !$onehot0(done)) viol++;
    prev_start = txStart;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag, input logic [31:0] exp);
    int n = 0;
    while (grant == '0 && n < 200) begin
      tick();
      n++;
    end
    chk(tag, grant, exp);
  endtask

  task automatic wait_start(input string tag, input int idx, input logic [7:0] exp_data,
                            input logic [7:0] next_data);
    int n = 0;
    tick();
    while (!txStart && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_start"}, txStart, 1);
    chk({tag, "_data"}, txData, exp_data);
    chk({tag, "_ack"}, byte_ack, 32'd1 << idx);
    req_data[idx*8 +: 8] = next_data;
  endtask

  task automatic wait_done(input string tag, input logic [31:0] exp);
    int n = 0;
    tick();
    while (done == '0 && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, done, exp);
    chk({tag, "_grant_clr"}, grant, 0);
  endtask

  initial begin
    int t0, td, s0, a0;
    reset = 1'b1; req = '0; req_len = '0; req_data = '0; txBusy = 1'b0;
    repeat (2) tick();
    chk("rst_grant", grant, 0);
    chk("rst_ack", byte_ack, 0);
    chk("rst_done", done, 0);
    chk("rst_start", txStart, 0);
    chk("rst_data", txData, 0);
    reset = 1'b0;
    tick();

    // Single packet, UART busy 10 cycles per byte
    req_len[0*LENW +: LENW] = 6'd3;
    req_data[7:0] = 8'hA1;
    req = 4'b0001;
    t0 = cyc;
    wait_grant("t1_grant", 4'b0001);
    chk("t1_grant_lat", cyc - t0, 1);
    t0 = cyc;
    wait_start("t1_b0", 0, 8'hA1, 8'hA2);
    chk("t1_start_lat", cyc - t0, 1);
    t0 = cyc;
    txBusy = 1'b1; repeat (10) tick(); txBusy = 1'b0;
    wait_start("t1_b1", 0, 8'hA2, 8'hA3);
    chk("t1_gap1", cyc - t0, 11);
    t0 = cyc;
    txBusy = 1'b1; repeat (10) tick(); txBusy = 1'b0;
    wait_start("t1_b2", 0, 8'hA3, 8'h00);
    chk("t1_gap2", cyc - t0, 11);
    wait_done("t1", 4'b0001);
    req = 4'b0000;
    repeat (3) tick();
    chk("t1_no_regrant", grant, 0);
    chk("t1_n_start", n_start, 3);
    chk("t1_n_ack", n_ack, 3);
    chk("t1_n_done", n_done, 1);

    // Round-robin with all four requesting continuously
    reset = 1'b1; tick(); reset = 1'b0; tick();
    for (int i = 0; i < NREQ; i++) begin
      req_len[i*LENW +: LENW] = 6'd1;
      req_data[i*8 +: 8] = 8'(8'h10 + i);
    end
    req = 4'b1111;
    td = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant("t2_grant", 32'd1 << (k % NREQ));
      if (k > 0) chk("t2_pkt_gap", cyc - td, 2);
      wait_start("t2_byte", k % NREQ, 8'(8'h10 + (k % NREQ)), 8'(8'h10 + (k % NREQ)));
      wait_done("t2", 32'd1 << (k % NREQ));
      td = cyc;
    end
    req = 4'b0000;
    repeat (2) tick();

    // Atomicity: requester 1 arrives while requester 2 is mid-packet
    req_len[2*LENW +: LENW] = 6'd5;
    req_data[2*8 +: 8] = 8'h50;
    req = 4'b0100;
    wait_grant("t3_grant", 4'b0100);
    for (int b = 0; b < 5; b++) begin
      wait_start("t3_byte", 2, 8'(8'h50 + b), 8'(8'h51 + b));
      chk("t3_grant_hold", grant, 4'b0100);
      if (b == 1) begin
        req_len[1*LENW +: LENW] = 6'd1;
        req_data[1*8 +: 8] = 8'h77;
        req[1] = 1'b1;
      end
    end
    wait_done("t3", 4'b0100);
    req[2] = 1'b0;
    wait_grant("t3_next_grant", 4'b0010);
    wait_start("t3_r1", 1, 8'h77, 8'h00);
    wait_done("t3_r1", 4'b0010);
    req = 4'b0000;
    repeat (2) tick();

    // Zero-length packet
    req_len[3*LENW +: LENW] = 6'd0;
    req = 4'b1000;
    s0 = n_start;
    wait_grant("t4_grant", 4'b1000);
    t0 = cyc;
    wait_done("t4", 4'b1000);
    chk("t4_grant_len", cyc - t0, 1);
    req = 4'b0000;
    repeat (2) tick();
    chk("t4_no_start", n_start - s0, 0);

    // Busy hold-off for 50 cycles
    req_len[0*LENW +: LENW] = 6'd1;
    req_data[7:0] = 8'h3C;
    txBusy = 1'b1;
    req = 4'b0001;
    wait_grant("t5_grant", 4'b0001);
    s0 = n_start; a0 = n_ack;
    repeat (50) begin
      tick();
      chk("t5_hold", {txStart, byte_ack}, 0);
    end
    chk("t5_hold_cnt", (n_start - s0) + (n_ack - a0), 0);
    txBusy = 1'b0;
    t0 = cyc;
    wait_start("t5_byte", 0, 8'h3C, 8'h00);
    chk("t5_lat", cyc - t0, 1);
    wait_done("t5", 4'b0001);
    req = 4'b0000;
    repeat (2) tick();

    // Reset in the middle of requester 1's packet; pointer returns to NREQ-1
    req_len[0*LENW +: LENW] = 6'd4;
    req_len[1*LENW +: LENW] = 6'd4;
    req_data[7:0] = 8'h60;
    req_data[15:8] = 8'h70;
    req = 4'b0011;
    wait_grant("t6_grant_pre", 4'b0010);
    wait_start("t6_pre0", 1, 8'h70, 8'h71);
    wait_start("t6_pre1", 1, 8'h71, 8'h72);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_start", txStart, 0);
    chk("t6_rst_ack", byte_ack, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_data", txData, 0);
    req_data[15:8] = 8'h70;
    tick();
    reset = 1'b0;
    s0 = n_start;
    wait_grant("t6_grant_post", 4'b0001);
    for (int b = 0; b < 4; b++) wait_start("t6_r0", 0, 8'(8'h60 + b), 8'(8'h61 + b));
    wait_done("t6_r0", 4'b0001);
    req[0] = 1'b0;
    wait_grant("t6_grant_r1", 4'b0010);
    for (int b = 0; b < 4; b++) wait_start("t6_r1", 1, 8'(8'h70 + b), 8'(8'h71 + b));
    wait_done("t6_r1", 4'b0010);
    req = 4'b0000;
    repeat (2) tick();
    chk("t6_n_start", n_start - s0, 8);

    chk("protocol_viol", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
